// File: rtl/vga_mem_arb.sv
// vga_mem_arb: arbitrates display fetches and host accesses onto one synchronous-read memory.
// Optional macro VGA_MEM_ARB_STARVE_EN adds forced host grants after STARVE_LIM denied cycles.
module vga_mem_arb #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int STARVE_LIM = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_miss,
  output logic [7:0]        miss_cnt,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_HOST
  } owner_t;

  if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_lim_check
    $error("vga_mem_arb: STARVE_LIM must be within 1..255");
  end

  logic   force_host;
  logic   disp_gnt;
  owner_t tag_a;
  owner_t tag_b;

`ifdef VGA_MEM_ARB_STARVE_EN
  logic [7:0] starve_cnt;
  logic [7:0] miss_q;

  assign force_host = host_valid && (starve_cnt == 8'(STARVE_LIM));
  assign disp_miss  = !reset && force_host && disp_req;
  assign miss_cnt   = miss_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      miss_q     <= '0;
    end else begin
      if (!host_valid || host_ready)
        starve_cnt <= '0;
      else
        starve_cnt <= starve_cnt + 8'd1;
      if (disp_miss && miss_q != '1)
        miss_q <= miss_q + 8'd1;
    end
  end
`else
  assign force_host = 1'b0;
  assign disp_miss  = 1'b0;
  assign miss_cnt   = '0;
`endif

  // host_ready doubles as the host handshake; it is mutually exclusive with disp_gnt
  assign host_ready = !reset && host_valid && (!disp_req || force_host);
  assign disp_gnt   = !reset && disp_req && !force_host;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_a     <= OWN_NONE;
      tag_b     <= OWN_NONE;
    end else begin
      mem_en <= disp_gnt || host_ready;
      mem_we <= host_ready && host_we;
      tag_b  <= tag_a;
      if (disp_gnt) begin
        mem_addr <= disp_addr;
        tag_a    <= OWN_DISP;
      end else if (host_ready) begin
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
        tag_a     <= host_we ? OWN_NONE : OWN_HOST;
      end else begin
        tag_a <= OWN_NONE;
      end
    end
  end

  assign disp_valid  = (tag_b == OWN_DISP);
  assign host_rvalid = (tag_b == OWN_HOST);
  assign disp_data   = disp_valid  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_mem_arb.sv
// tb_vga_mem_arb: directed and random stimulus against a cycle-indexed grant history model.
module tb_vga_mem_arb;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LIM = 4;
  localparam int NC  = 8192;
  localparam int O_NONE = 0, O_D = 1, O_HR = 2, O_HW = 3;
`ifdef VGA_MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          disp_miss;
  logic [7:0]    miss_cnt;
  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vga_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_miss(disp_miss), .miss_cnt(miss_cnt),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    if (a == 12'h010) return 8'hA5;
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3C;
  endfunction

  // Behavioural memory: read data appears the cycle after an enabled read.
  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? mem_f(mem_addr) : DW'($urandom);

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 2;
  int            own   [0:NC-1];
  logic [AW-1:0] oaddr [0:NC-1];
  logic [DW-1:0] odata [0:NC-1];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wd   = '0;
  int            scnt      = 0;
  int            exp_mc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic dr, input logic [AW-1:0] da, input logic hv,
                      input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    logic frc, rdy, miss;
    int p, r;
    if (cyc >= NC - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NC - 1);
      $fatal(1);
    end
    disp_req = dr; disp_addr = da; host_valid = hv;
    host_we = hw; host_addr = ha; host_wdata = hd;
    @(negedge clk);
    p = own[cyc-1];
    r = own[cyc-2];
    if (p != O_NONE) last_addr = oaddr[cyc-1];
    if (p == O_HR || p == O_HW) last_wd = odata[cyc-1];
    chk("mem_en", mem_en, p != O_NONE);
    chk("mem_we", mem_we, p == O_HW);
    chk("mem_addr", mem_addr, last_addr);
    chk("mem_wdata", mem_wdata, last_wd);
    chk("disp_valid", disp_valid, r == O_D);
    chk("host_rvalid", host_rvalid, r == O_HR);
    if (r == O_D)  chk("disp_data", disp_data, mem_f(oaddr[cyc-2]));
    if (r == O_HR) chk("host_rdata", host_rdata, mem_f(oaddr[cyc-2]));
    chk("miss_cnt", miss_cnt, exp_mc);
    frc  = STARVE_ON && hv && (scnt == LIM);
    rdy  = hv && (!dr || frc);
    miss = frc && dr;
    chk("host_ready", host_ready, rdy);
    chk("disp_miss", disp_miss, miss);
    if (miss && exp_mc < 255) exp_mc++;
    scnt = (!hv || rdy) ? 0 : scnt + 1;
    own[cyc]   = rdy ? (hw ? O_HW : O_HR) : ((dr && !frc) ? O_D : O_NONE);
    oaddr[cyc] = rdy ? ha : da;
    odata[cyc] = hd;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; disp_req = 1'b1; host_valid = 1'b1; host_we = 1'b0;
    own[cyc-1] = O_NONE;
    own[cyc-2] = O_NONE;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_host_ready", host_ready, 1'b0);
      chk("rst_disp_miss", disp_miss, 1'b0);
      chk("rst_miss_cnt", miss_cnt, 8'd0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_disp_valid", disp_valid, 1'b0);
      chk("rst_disp_data", disp_data, '0);
      chk("rst_host_rvalid", host_rvalid, 1'b0);
      chk("rst_host_rdata", host_rdata, '0);
      own[cyc] = O_NONE;
      @(posedge clk); #1;
      cyc++;
    end
    reset = 1'b0; disp_req = 1'b0; host_valid = 1'b0;
    scnt = 0; exp_mc = 0; last_addr = '0; last_wd = '0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      own[i] = O_NONE; oaddr[i] = '0; odata[i] = '0;
    end
    disp_addr = '0; host_addr = '0; host_wdata = '0; host_we = 1'b0;
    do_reset(2);

    // single display fetch, read data 0xA5
    step(1'b1, 12'h010, 1'b0, 1'b0, '0, '0);
    idle(3);

    // host write with no display traffic
    step(1'b0, '0, 1'b1, 1'b1, 12'h123, 8'h5A);
    idle(3);

    // display blocks a host read for three cycles
    for (int i = 0; i < 3; i++) step(1'b1, AW'(12'h200 + i), 1'b1, 1'b0, 12'h020, 8'h11);
    step(1'b0, '0, 1'b1, 1'b0, 12'h020, 8'h22);
    idle(3);

    // alternating display / host reads every cycle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1'b1, AW'($urandom), 1'b0, 1'b0, '0, '0);
      else            step(1'b0, '0, 1'b1, 1'b0, AW'($urandom), DW'($urandom));
    end
    idle(3);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, AW'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
    idle(3);

    // host read handshake, then reset in the following cycle
    step(1'b0, '0, 1'b1, 1'b0, 12'h045, 8'h00);
    do_reset(2);
    idle(4);

    // continuous contention
    for (int i = 0; i < 20; i++) step(1'b1, AW'($urandom), 1'b1, 1'b0, AW'($urandom), DW'($urandom));
    idle(2);

`ifdef VGA_MEM_ARB_STARVE_EN
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, AW'($urandom), 1'b1, 1'b0, 12'h077, 8'h00);
    chk("miss_first", miss_cnt, 8'd1);
    for (int i = 0; i < 1500; i++) step(1'b1, AW'($urandom), 1'b1, 1'b0, AW'($urandom), DW'($urandom));
    idle(1);
    chk("miss_sat", miss_cnt, 8'd255);
    idle(2);
`else
    chk("miss_off", miss_cnt, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_mem_arb.md
VGA_MEM_ARB -- requirements
Module: vga_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 12, shared memory address width.
REQ-002 Parameter DATA_W, default 8, shared memory data width.
REQ-003 Parameter STARVE_LIM, default 15, legal range 1..255; consecutive host-denied cycles before a forced host grant.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 disp_req  in  1  display fetch request, one word per asserted cycle.
REQ-008 disp_addr  in  ADDR_W  display fetch address.
REQ-009 disp_valid  out  1  display read data valid.
REQ-010 disp_data  out  DATA_W  display read data.
REQ-011 disp_miss  out  1  one-cycle pulse: a display request was dropped.
REQ-012 miss_cnt  out  8  saturating count of dropped display requests.
REQ-013 host_valid  in  1  host request valid.
REQ-014 host_ready  out  1  host request accepted this cycle.
REQ-015 host_we  in  1  1 = write, 0 = read.
REQ-016 host_addr  in  ADDR_W  host address.
REQ-017 host_wdata  in  DATA_W  host write data.
REQ-018 host_rvalid  out  1  host read data valid.
REQ-019 host_rdata  out  DATA_W  host read data.
REQ-020 mem_en, mem_we  out  1 each  memory enable and write strobe, registered.
REQ-021 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; both registered.
REQ-022 mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after mem_en.

Function
REQ-023 Each cycle exactly one requester or none is granted. The grant drives mem_en/mem_we/mem_addr/mem_wdata in the following cycle.
REQ-024 Display has priority. host_ready = host_valid && !disp_req, except when forced per REQ-031.
REQ-025 Display request in cycle N -> mem_en=1, mem_we=0, mem_addr=disp_addr in N+1 -> disp_valid=1 and disp_data=mem_rdata in N+2. Latency is fixed at 2 cycles.
REQ-026 Host handshake (host_valid && host_ready) in cycle N -> memory access in N+1. For a read, host_rvalid=1 and host_rdata=mem_rdata in N+2. A write produces no response.
REQ-027 Back-to-back grants of either requester are allowed every cycle. A 2-deep owner tag pipeline routes each returned word to exactly one of disp_valid or host_rvalid.
REQ-028 No grant -> mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
REQ-029 host_wdata and host_addr are captured only on a handshake. Changes while host_ready=0 have no effect.
REQ-030 disp_data and host_rdata are don't-care when their valid is low.

Reset
REQ-031 (forced grant, STARVE only) Defined in REQ-037.
REQ-032 While reset=1: all outputs are 0, the tag pipeline is cleared, the starvation counter is 0 and miss_cnt is 0.
REQ-033 Reset asserted mid-access: the in-flight disp_valid and host_rvalid are never asserted after reset release.
REQ-034 The first grant is possible in the first clock edge after reset deasserts.

Configuration
REQ-035 Macro VGA_MEM_ARB_STARVE_EN compiles in starvation protection.
REQ-036 Without the macro:
  - strict display priority;
  - disp_miss=0 and miss_cnt=0 constant;
  - STARVE_LIM is ignored.
REQ-037 With the macro:
  - An 8-bit counter increments each cycle host_valid && !host_ready, and clears on a handshake or when host_valid=0.
  - When the counter equals STARVE_LIM, host_ready=1 that cycle even if disp_req=1.
  - The display request in that cycle is dropped: no memory access and no disp_valid.
  - disp_miss pulses in the same cycle.
  - miss_cnt increments, saturating at 255.
  - The counter clears.

Verification
REQ-038 disp_req=1 with disp_addr=0x010 for one cycle, mem_rdata=0xA5 in N+2 -> mem_en=1 and mem_addr=0x010 in N+1; disp_valid=1 and disp_data=0xA5 in N+2.
REQ-039 Host write addr=0x123, wdata=0x5A with disp_req=0 -> host_ready=1 in N; mem_we=1, mem_addr=0x123, mem_wdata=0x5A in N+1; no host_rvalid.
REQ-040 disp_req=1 and host read (addr 0x020) both valid for 3 cycles, then disp_req=0 -> host_ready=0 for 3 cycles, then 1. Exactly 3 disp_valid and then 1 host_rvalid, each in its own cycle.
REQ-041 Alternating disp and host reads every cycle for 8 cycles -> returned words are routed by owner with no loss or swap (checked by a scoreboard).
REQ-042 Macro on, STARVE_LIM=4, disp_req=1 continuously, host_valid=1 -> host_ready=1 on the 5th cycle, disp_miss pulses once, miss_cnt=1. Repeating this 300 times gives miss_cnt=255.
REQ-043 Reset asserted in the cycle after a host read handshake -> host_rvalid stays 0 and all outputs are 0 until a new request arrives.
